cpu_inta_sequencer: RTL and testbench

//  CPU-side end of the 8259A interrupt handshake. Samples the PIC INT line,

---
 rtl/cpu_inta_sequencer.sv | 152 +++++++++++++++
 tb/tb_cpu_inta_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_inta_sequencer.sv
// CPU-side 8259A interrupt acknowledge sequencer: synchronises INT, issues two
// active-low INTA pulses, captures the vector on the second and hands it to the core.
//
// state     | meaning
// S_IDLE    | waiting for synchronised INT with IF_flag set
// S_P1      | first INTA pulse (INTA low, LOCK high)
// S_GAP     | INTA high between pulses, bus still locked
// S_P2      | second INTA pulse, vector captured on its final edge
// S_DELIVER | vector_valid high until the core acknowledges
// S_HOLDOFF | INT ignored for HOLDOFF_CYCLES after the acknowledge
module cpu_inta_sequencer #(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2,
    parameter int HOLDOFF_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       INT,
    input  logic       IF_flag,
    input  logic [7:0] data_bus,
    input  logic       vector_ack,
    output logic       INTA,
    output logic       LOCK,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy
);

    localparam int MAX_LG = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
    localparam int MAX_P  = (MAX_LG > HOLDOFF_CYCLES) ? MAX_LG : HOLDOFF_CYCLES;
    localparam int CW     = $clog2(MAX_P + 1);

    // Counters load N-1 on state entry and leave the state on the edge they read zero.
    localparam logic [CW-1:0] LOW_LOAD  = CW'(INTA_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(INTA_GAP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_P1      = 3'd1,
        S_GAP     = 3'd2,
        S_P2      = 3'd3,
        S_DELIVER = 3'd4,
        S_HOLDOFF = 3'd5
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          int_m, int_s;
    logic          capture, consume;
    logic          inta_d, lock_d, busy_d;
    logic          cnt_zero;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            int_m        <= 1'b0;
            int_s        <= 1'b0;
            INTA         <= 1'b1;
            LOCK         <= 1'b0;
            busy         <= 1'b0;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            int_m <= INT;
            int_s <= int_m;
            INTA  <= inta_d;
            LOCK  <= lock_d;
            busy  <= busy_d;
            if (capture) begin
                vector       <= data_bus;
                vector_valid <= 1'b1;
            end else if (consume) begin
                vector_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        capture = 1'b0;
        consume = 1'b0;
        case (state)
            S_IDLE: begin
                if (int_s && IF_flag) begin
                    state_d = S_P1;
                    cnt_d   = LOW_LOAD;
                end
            end
            S_P1: begin
                if (cnt_zero) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = S_P2;
                    cnt_d   = LOW_LOAD;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_P2: begin
                if (cnt_zero) begin
                    state_d = S_DELIVER;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_DELIVER: begin
                if (vector_valid && vector_ack) begin
                    consume = 1'b1;
                    if (HOLDOFF_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLDOFF;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            S_HOLDOFF: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with it.
    always_comb begin
        inta_d = !((state_d == S_P1) || (state_d == S_P2));
        lock_d = (state_d == S_P1) || (state_d == S_GAP) || (state_d == S_P2);
        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_cpu_inta_sequencer.sv
// Randomised bench for cpu_inta_sequencer: a timeline-based reference model
// predicts every output after each edge, plus a few directed scenarios.
module tb_cpu_inta_sequencer;

    localparam int L = 2;
    localparam int G = 2;
    localparam int H = 4;
    localparam int MAXE = 16384;

    logic       clk = 1'b0;
    logic       reset;
    logic       INT;
    logic       IF_flag;
    logic [7:0] data_bus;
    logic       vector_ack;
    logic       INTA;
    logic       LOCK;
    logic [7:0] vector;
    logic       vector_valid;
    logic       busy;

    always #5 clk = ~clk;

    cpu_inta_sequencer #(
        .INTA_LOW_CYCLES(L),
        .INTA_GAP_CYCLES(G),
        .HOLDOFF_CYCLES (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .INT         (INT),
        .IF_flag     (IF_flag),
        .data_bus    (data_bus),
        .vector_ack  (vector_ack),
        .INTA        (INTA),
        .LOCK        (LOCK),
        .vector      (vector),
        .vector_valid(vector_valid),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tracks absolute edge numbers of sequence start and ack.
    typedef enum int {M_IDLE, M_SEQ, M_DELIVER, M_HOLD} mmode_t;

    mmode_t     mode     = M_IDLE;
    int         e        = 0;
    int         last_rst = -10;
    int         start    = 0;
    int         hold_end = 0;
    bit         m_vv     = 1'b0;
    bit [7:0]   m_vec    = 8'h00;
    bit         m_inta   = 1'b1;
    bit         m_lock   = 1'b0;
    bit         m_busy   = 1'b0;
    bit         hist [0:MAXE-1];

    always @(posedge clk) begin
        bit int_seen;
        int p;
        int_seen = (e >= 2 && (e - 2) > last_rst) ? hist[(e - 2) % MAXE] : 1'b0;
        if (reset) begin
            mode     = M_IDLE;
            m_vv     = 1'b0;
            m_vec    = 8'h00;
            last_rst = e;
        end else begin
            case (mode)
                M_IDLE: if (int_seen && IF_flag) begin
                    mode  = M_SEQ;
                    start = e;
                end
                M_SEQ: if (e - start == 2 * L + G) begin
                    m_vec = data_bus;
                    m_vv  = 1'b1;
                    mode  = M_DELIVER;
                end
                M_DELIVER: if (m_vv && vector_ack) begin
                    m_vv     = 1'b0;
                    hold_end = e + H;
                    mode     = (H == 0) ? M_IDLE : M_HOLD;
                end
                M_HOLD: if (e == hold_end) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
        end
        if (mode == M_SEQ) begin
            p      = e - start;
            m_inta = !(p < L || p >= L + G);
            m_lock = 1'b1;
        end else begin
            m_inta = 1'b1;
            m_lock = 1'b0;
        end
        m_busy = (mode != M_IDLE);
        hist[e % MAXE] = INT;
        e++;
    end

    always @(negedge clk) begin
        if (e > 0) begin
            check("INTA", INTA, m_inta);
            check("LOCK", LOCK, m_lock);
            check("busy", busy, m_busy);
            check("vector_valid", vector_valid, m_vv);
            check("vector", vector, m_vec);
        end
    end

    initial begin
        int n;
        int pulses;
        reset = 1'b1;
        INT = 1'b0;
        IF_flag = 1'b0;
        vector_ack = 1'b0;
        data_bus = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_inta", INTA, 1);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic sequence: vector 4B captured 8 edges after INT first sampled.
        IF_flag = 1'b1;
        data_bus = 8'h4B;
        INT = 1'b1;
        repeat (12) @(negedge clk);
        check("t1_vector", vector, 8'h4B);
        check("t1_valid", vector_valid, 1);
        vector_ack = 1'b1;
        INT = 1'b0;
        @(negedge clk);
        vector_ack = 1'b0;
        repeat (8) @(negedge clk);

        // IF_flag low holds INT off; raising it starts on the next edge.
        IF_flag = 1'b0;
        INT = 1'b1;
        repeat (20) @(negedge clk);
        check("t2_busy", busy, 0);
        check("t2_inta", INTA, 1);
        IF_flag = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (INTA !== 1'b0 && n < 20);
        check("t2_latency", n, 1);
        // INT drops mid-sequence; sequence still completes.
        repeat (2) @(negedge clk);
        INT = 1'b0;
        data_bus = 8'h47;
        repeat (6) @(negedge clk);
        check("t3_vector", vector, 8'h47);
        check("t3_valid", vector_valid, 1);
        vector_ack = 1'b1;
        @(negedge clk);
        vector_ack = 1'b0;
        repeat (8) @(negedge clk);

        // Reset while in the second pulse.
        INT = 1'b1;
        n = 0;
        while (!(mode == M_SEQ && (e - 1 - start) >= L + G) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_reach_p2", int'(n < 50), 1);
        reset = 1'b1;
        INT = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("t4_inta", INTA, 1);
        check("t4_lock", LOCK, 0);
        check("t4_busy", busy, 0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (vector_valid === 1'b1) pulses++;
        end
        check("t4_no_vv", pulses, 0);

        // Ack held high through capture: valid lasts exactly one clock.
        vector_ack = 1'b1;
        INT = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (n == 0) INT = 1'b0;
            if (vector_valid === 1'b1) pulses++;
        end
        check("t6_vv_pulses", pulses, 1);
        vector_ack = 1'b0;
        INT = 1'b0;
        repeat (6) @(negedge clk);

        // Randomised traffic.
        repeat (4000) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) INT = ~INT;
            if ($urandom_range(0, 15) == 0) IF_flag = ~IF_flag;
            data_bus   = 8'($urandom);
            vector_ack = ($urandom_range(0, 3) == 0);
            reset      = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
